mips_multicycle_ctrl: RTL and testbench
=======================================

# mips_multicycle_ctrl

Main control unit for the multicycle MIPS datapath: a Moore state machine that sequences instruction fetch, decode, execute, memory and writeback, plus an ALU decoder. Reads the opcode and funct fields of the instruction register and the ALU zero flag. Drives every mux select, register enable and ALU control input of the datapath, and the memory write strobe. One instance sits beside the datapath in the processor top level.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; forces state to FETCH
- op  in  6  instr[31:26] from the instruction register
- funct  in  6  instr[5:0] from the instruction register
- zero  in  1  ALU zero flag, combinational from the datapath
- memtoreg  out  1  wd3 select: 0 ALUOut, 1 data register
- regdst  out  1  a3 select: 0 rt, 1 rd
- regwrite  out  1  register file write enable
- alusrca  out  1  0 PC, 1 A register
- alusrcb  out  2  00 B, 01 constant 4, 10 signimm, 11 signimm<<2
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target
- IorD  out  1  memory address: 0 PC, 1 ALUOut
- irwrite  out  1  instruction register enable
- memwrite  out  1  memory write strobe
- pcen  out  1  PC enable = pcwrite | (branch & zero)

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- Any other opcode is treated as a NOP: DECODE returns to FETCH; no register or memory write.
- State register is 4 bits. States and transitions:
  - FETCH -> DECODE
  - DECODE -> MEMADR (lw/sw), RTYPEEX, BEQEX, ADDIEX, JEX, or FETCH (illegal opcode)
  - MEMADR -> MEMRD (lw) or MEMWR (sw); MEMRD -> MEMWB -> FETCH; MEMWR -> FETCH
  - RTYPEEX -> RTYPEWB -> FETCH; ADDIEX -> ADDIWB -> FETCH; BEQEX -> FETCH; JEX -> FETCH
- Asserted outputs per state; unlisted 1-bit outputs are 0 and unlisted selects are 0:
  - FETCH: IorD=0, alusrca=0, alusrcb=01, alucontrol=add, pcsrc=00, irwrite=1, pcwrite=1
  - DECODE: alusrca=0, alusrcb=11, alucontrol=add (branch target into ALUOut)
  - MEMADR / ADDIEX: alusrca=1, alusrcb=10, alucontrol=add
  - MEMRD: IorD=1. MEMWR: IorD=1, memwrite=1
  - MEMWB: regdst=0, memtoreg=1, regwrite=1
  - RTYPEEX: alusrca=1, alusrcb=00, alucontrol from funct
  - RTYPEWB: regdst=1, memtoreg=0, regwrite=1
  - ADDIWB: regdst=0, memtoreg=0, regwrite=1
  - BEQEX: alusrca=1, alusrcb=00, alucontrol=sub, pcsrc=01, branch=1
  - JEX: pcsrc=10, pcwrite=1
- Funct decode (RTYPEEX only): 100000 add->010, 100010 sub->110, 100100 and->000, 100101 or->001, 101010 slt->111. Any other funct gives 010; writeback still occurs.
- pcen is the only output that depends on an input (zero). Its only input-dependent state is BEQEX. All other outputs are pure functions of state.

## Timing
- Reset, asynchronous: state becomes FETCH immediately, so outputs show FETCH values during reset (irwrite=1, pcen=1). This is harmless because the datapath registers are held in reset too.
- First fetch completes on the first rising edge after reset deasserts.
- CPI: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal opcode 2.
- op and funct are sampled in DECODE and later states. They are stable because irwrite is asserted only in FETCH.
- memwrite is high for exactly one cycle per sw. regwrite is high for exactly one cycle per lw, R-type and addi.
- Reset asserted mid-instruction aborts it. No write occurs in any cycle where reset is high, because the state is forced to FETCH.

## Test plan
- Reset then release with op=100011 held: states run FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH. MEMRD has IorD=1. MEMWB has memtoreg=1, regwrite=1.
- op=000000, funct=101010: RTYPEEX gives alucontrol=111, alusrca=1, alusrcb=00. RTYPEWB gives regdst=1, regwrite=1. Repeat with funct=111111 and expect alucontrol=010.
- op=000100 with zero=1 in BEQEX: pcen=1, pcsrc=01, alucontrol=110. With zero=0: pcen=0. Returns to FETCH next cycle in both cases.
- op=101011: memwrite pulses exactly one cycle in MEMWR with IorD=1, regwrite=0 throughout. op=000010: JEX gives pcsrc=10, pcen=1.
- op=111111: DECODE -> FETCH; regwrite and memwrite stay 0.
- Assert reset asynchronously mid-cycle while in MEMWR: memwrite drops without waiting for a clock edge, FETCH outputs appear, and the lw sequence runs normally after release.

Source files
------------

// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// Carries instruction fields and zero flag in, every mux select/enable out.
// No flow control: the datapath consumes the controls every cycle.
interface mips_multicycle_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
    logic [1:0] pcsrc;
    logic       IorD;
    logic       irwrite;
    logic       memwrite;
    logic       pcen;

    // Controller side: reads the instruction fields, drives the datapath.
    modport master (
        input  op, funct, zero,
        output memtoreg, regdst, regwrite, alusrca, alusrcb, alucontrol,
               pcsrc, IorD, irwrite, memwrite, pcen
    );

    // Datapath side: supplies the instruction fields, obeys the controls.
    modport slave (
        output op, funct, zero,
        input  memtoreg, regdst, regwrite, alusrca, alusrcb, alucontrol,
               pcsrc, IorD, irwrite, memwrite, pcen
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control: Moore FSM sequencing fetch..writeback plus ALU decode.
// Latency: 2 (illegal) to 5 (lw) cycles per instruction; outputs combinational from state.
// No backpressure: the FSM advances on every rising clock edge.
module mips_multicycle_ctrl (
    input  logic                          clk,
    input  logic                          reset,
    mips_multicycle_ctrl_if.master        bus
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t     state_q;
    state_t     state_d;

    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
    logic [1:0] pcsrc;
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       pcwrite;
    logic       branch;
    logic [2:0] funct_alu;

    // State register; reset lands in FETCH immediately so no write can fire while held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // R-type ALU decode; unknown funct falls back to add so writeback still sees a value.
    always_comb begin
        funct_alu = ALU_ADD;
        case (bus.funct)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_alu = ALU_ADD;
        endcase
    end

    // Next-state and Moore outputs; everything defaults to deasserted / select 0.
    always_comb begin
        state_d    = S_FETCH;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        alucontrol = 3'b000;
        pcsrc      = 2'b00;
        iord       = 1'b0;
        irwrite    = 1'b0;
        memwrite   = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        case (state_q)
            S_FETCH: begin
                alusrcb    = 2'b01;
                alucontrol = ALU_ADD;
                irwrite    = 1'b1;
                pcwrite    = 1'b1;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut.
                alusrcb    = 2'b11;
                alucontrol = ALU_ADD;
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = ALU_ADD;
                state_d    = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_RTYPEEX: begin
                alusrca    = 1'b1;
                alucontrol = funct_alu;
                state_d    = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BEQEX: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                branch     = 1'b1;
                state_d    = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = ALU_ADD;
                state_d    = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign bus.memtoreg   = memtoreg;
    assign bus.regdst     = regdst;
    assign bus.regwrite   = regwrite;
    assign bus.alusrca    = alusrca;
    assign bus.alusrcb    = alusrcb;
    assign bus.alucontrol = alucontrol;
    assign bus.pcsrc      = pcsrc;
    assign bus.IorD       = iord;
    assign bus.irwrite    = irwrite;
    assign bus.memwrite   = memwrite;
    // Only output touched by an input: branch taken when the ALU compare is zero.
    assign bus.pcen       = pcwrite | (branch & bus.zero);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized self-checking bench for mips_multicycle_ctrl.
// Expected control words come from a per-instruction phase table model.
// Inputs driven 1 time unit after rising edges, outputs sampled on falling edges.
module tb_mips_multicycle_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mips_multicycle_ctrl_if bus ();

    mips_multicycle_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed control word: {memtoreg,regdst,regwrite,alusrca,alusrcb,alucontrol,pcsrc,IorD,irwrite,memwrite,pcen}
    logic [14:0] obs;
    assign obs = {bus.memtoreg, bus.regdst, bus.regwrite, bus.alusrca, bus.alusrcb,
                  bus.alucontrol, bus.pcsrc, bus.IorD, bus.irwrite, bus.memwrite, bus.pcen};

    function automatic logic [14:0] mk(input logic m2r, input logic rd, input logic rw,
                                       input logic sa, input logic [1:0] sb,
                                       input logic [2:0] alu, input logic [1:0] ps,
                                       input logic ad, input logic ir, input logic mw,
                                       input logic pe);
        return {m2r, rd, rw, sa, sb, alu, ps, ad, ir, mw, pe};
    endfunction

    // Cycles per instruction by opcode.
    function automatic int cpi(input logic [5:0] op);
        case (op)
            6'b100011: return 5;
            6'b101011: return 4;
            6'b000000: return 4;
            6'b001000: return 4;
            6'b000100: return 3;
            6'b000010: return 3;
            default:   return 2;
        endcase
    endfunction

    function automatic logic [2:0] funct_op(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected controls for cycle idx of an instruction (0 = fetch, 1 = decode).
    function automatic logic [14:0] expect_word(input logic [5:0] op, input logic [5:0] f,
                                                input logic z, input int idx);
        logic [14:0] fetch_w, decode_w, adr_w;
        fetch_w  = mk(0,0,0, 0,2'b01,3'b010,2'b00, 0,1,0,1);
        decode_w = mk(0,0,0, 0,2'b11,3'b010,2'b00, 0,0,0,0);
        adr_w    = mk(0,0,0, 1,2'b10,3'b010,2'b00, 0,0,0,0);
        if (idx == 0) return fetch_w;
        if (idx == 1) return decode_w;
        case (op)
            6'b100011: case (idx)
                2: return adr_w;
                3: return mk(0,0,0, 0,2'b00,3'b000,2'b00, 1,0,0,0);
                default: return mk(1,0,1, 0,2'b00,3'b000,2'b00, 0,0,0,0);
            endcase
            6'b101011: case (idx)
                2: return adr_w;
                default: return mk(0,0,0, 0,2'b00,3'b000,2'b00, 1,0,1,0);
            endcase
            6'b000000: case (idx)
                2: return mk(0,0,0, 1,2'b00,funct_op(f),2'b00, 0,0,0,0);
                default: return mk(0,1,1, 0,2'b00,3'b000,2'b00, 0,0,0,0);
            endcase
            6'b001000: case (idx)
                2: return adr_w;
                default: return mk(0,0,1, 0,2'b00,3'b000,2'b00, 0,0,0,0);
            endcase
            6'b000100: return mk(0,0,0, 1,2'b00,3'b110,2'b01, 0,0,0,z);
            6'b000010: return mk(0,0,0, 0,2'b00,3'b000,2'b10, 0,0,0,1);
            default:   return fetch_w;
        endcase
    endfunction

    // Runs one whole instruction from its FETCH cycle and compares every cycle.
    // zmode: 0 drive zero=0, 1 drive zero=1, 2 random per cycle.
    task automatic exec_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                              input int zmode);
        logic [14:0] exp_w;
        for (int i = 0; i < cpi(o); i++) begin
            bus.op    = o;
            bus.funct = f;
            bus.zero  = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            @(negedge clk);
            exp_w = expect_word(o, f, bus.zero, i);
            checks++;
            if (obs !== exp_w) begin
                errors++;
                $display("FAIL %s cyc%0d op=%b funct=%b zero=%b: got %b expected %b",
                         name, i, o, f, bus.zero, obs, exp_w);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        logic [14:0] fw;
        fw = mk(0,0,0, 0,2'b01,3'b010,2'b00, 0,1,0,1);
        bus.op = 6'b100011; bus.funct = 6'd0; bus.zero = 1'b0;
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        checks++;
        if (obs !== fw) begin
            errors++;
            $display("FAIL reset_async: got %b expected %b", obs, fw);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs !== fw) begin
            errors++;
            $display("FAIL reset_held: got %b expected %b", obs, fw);
        end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_lw();
        exec_instr("lw", 6'b100011, 6'($urandom), 2);
    endtask

    task automatic test_rtype();
        exec_instr("rtype_slt", 6'b000000, 6'b101010, 2);
        exec_instr("rtype_bad_funct", 6'b000000, 6'b111111, 2);
        exec_instr("rtype_sub", 6'b000000, 6'b100010, 2);
        exec_instr("rtype_and", 6'b000000, 6'b100100, 2);
        exec_instr("rtype_or", 6'b000000, 6'b100101, 2);
        exec_instr("rtype_add", 6'b000000, 6'b100000, 2);
    endtask

    task automatic test_beq();
        exec_instr("beq_taken", 6'b000100, 6'($urandom), 1);
        exec_instr("beq_not_taken", 6'b000100, 6'($urandom), 0);
    endtask

    task automatic test_sw_j_addi();
        exec_instr("sw", 6'b101011, 6'($urandom), 2);
        exec_instr("j", 6'b000010, 6'($urandom), 2);
        exec_instr("addi", 6'b001000, 6'($urandom), 2);
    endtask

    task automatic test_illegal();
        exec_instr("illegal", 6'b111111, 6'($urandom), 2);
        exec_instr("after_illegal", 6'b100011, 6'($urandom), 2);
    endtask

    task automatic test_async_reset();
        logic [14:0] fw;
        logic [14:0] exp_w;
        fw = mk(0,0,0, 0,2'b01,3'b010,2'b00, 0,1,0,1);
        // Walk an sw up to its MEMWR cycle, then hit reset between edges.
        for (int i = 0; i < 4; i++) begin
            bus.op = 6'b101011; bus.funct = 6'd0; bus.zero = 1'b0;
            @(negedge clk);
            exp_w = expect_word(6'b101011, 6'd0, 1'b0, i);
            checks++;
            if (obs !== exp_w) begin
                errors++;
                $display("FAIL abort_sw cyc%0d: got %b expected %b", i, obs, exp_w);
            end
            if (i < 3) begin
                @(posedge clk);
                #1;
            end
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (bus.memwrite !== 1'b0 || obs !== fw) begin
            errors++;
            $display("FAIL abort_midcycle: got %b expected %b", obs, fw);
        end
        bus.op = 6'b100011;
        @(posedge clk);
        #1;
        checks++;
        if (obs !== fw) begin
            errors++;
            $display("FAIL abort_held: got %b expected %b", obs, fw);
        end
        reset = 1'b0;
        exec_instr("lw_after_abort", 6'b100011, 6'($urandom), 2);
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [6];
        logic [5:0] o;
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 4) == 0) o = 6'($urandom);
            else o = ops[$urandom_range(0, 5)];
            exec_instr("random", o, ($urandom_range(0, 1) == 1) ? 6'($urandom)
                                   : (6'b100000 | 6'($urandom_range(0, 10))), 2);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        bus.op = 6'd0; bus.funct = 6'd0; bus.zero = 1'b0;
        test_reset();
        test_lw();
        test_rtype();
        test_beq();
        test_sw_j_addi();
        test_illegal();
        test_async_reset();
        test_back_to_back();
        exec_instr("final_fetch", 6'b111111, 6'd0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
